// File: rtl/acc_adder_pkg.sv
// ---------------------------------------------------------------------------
// acc_adder_pkg
// Shared type definitions for the burst accumulator.
//   accState_t : FSM state encoding.
//     ACC - accumulating pair sums of the current burst
//     OUT - a finished burst result is being presented to the consumer
// ---------------------------------------------------------------------------
package acc_adder_pkg;

   typedef enum logic [0:0] {
      ACC = 1'b0,
      OUT = 1'b1
   } accState_t;

endpackage

// File: rtl/acc_sat_add.sv
// ---------------------------------------------------------------------------
// acc_sat_add
// Combinational adder for the accumulator stage. It adds the running
// accumulator to a zero-extended pair sum at one bit wider than the
// accumulator. The extra bit is the carry-out. The SAT parameter selects what
// happens to the sum on carry-out: wrap (keep the low bits) or clamp to
// all-ones.
//
// Parameters:
//   ACCWIDTH  : accumulator width
//   PSUMWIDTH : pair-sum width (must not exceed ACCWIDTH)
//   SAT       : 0 = wrap, 1 = clamp
// Ports:
//   acc   in  ACCWIDTH   current accumulator value
//   psum  in  PSUMWIDTH  pair sum from the input stage, unsigned
//   sum   out ACCWIDTH   wrapped or clamped result
//   carry out 1          carry-out of the full-width addition
// ---------------------------------------------------------------------------
module acc_sat_add #(
   parameter int ACCWIDTH  = 40,
   parameter int PSUMWIDTH = 33,
   parameter bit SAT       = 1'b0
) (
   input  logic [ACCWIDTH-1:0]  acc,
   input  logic [PSUMWIDTH-1:0] psum,
   output logic [ACCWIDTH-1:0]  sum,
   output logic                 carry
);

   logic [ACCWIDTH:0] wideSum;

   // Full-width add. The pair sum is zero-extended up to ACCWIDTH+1 bits, so
   // the top bit of the result is exactly the accumulator carry-out.
   always_comb begin
      wideSum = {1'b0, acc} + {{(ACCWIDTH + 1 - PSUMWIDTH){1'b0}}, psum};
   end

   assign carry = wideSum[ACCWIDTH];

   // The overflow policy is fixed at elaboration time. The clamp variant
   // replaces the wrapped value with all-ones whenever the carry fires. Once
   // the accumulator sits at all-ones, any further non-zero pair sum carries
   // again, so the value stays clamped.
   generate
      if (SAT) begin : gSat
         assign sum = carry ? {ACCWIDTH{1'b1}} : wideSum[ACCWIDTH-1:0];
      end else begin : gWrap
         assign sum = wideSum[ACCWIDTH-1:0];
      end
   endgenerate

endmodule

// File: rtl/acc_adder.sv
// ---------------------------------------------------------------------------
// acc_adder
// Pipelined burst accumulator. Each accepted beat contributes
// iData0 + iData1. The pair sums of a burst (ended by iLast) are reduced into
// one result with a sticky overflow flag. The result is handed out over a
// valid/ready handshake.
//
// Pipeline:
//   stage 1 : pair register (psum/pvalid/plast)
//   stage 2 : accumulator + result registers, driven by a 2-state FSM
//
// Parameters:
//   BITWIDTH : operand width
//   ACCWIDTH : accumulator/result width (>= BITWIDTH+1)
//   SAT      : 0 = wrap modulo 2^ACCWIDTH, 1 = clamp at 2^ACCWIDTH-1
// Ports:
//   iClk    in   1         clock, rising edge
//   iRst    in   1         synchronous active-high reset
//   iClr    in   1         synchronous clear, same effect as iRst
//   iValid  in   1         input beat valid
//   oReady  out  1         input beat accepted when iValid & oReady
//   iData0  in   BITWIDTH  operand 0
//   iData1  in   BITWIDTH  operand 1
//   iLast   in   1         final beat of a burst
//   oValid  out  1         result valid
//   iReady  in   1         result taken when oValid & iReady
//   oData   out  ACCWIDTH  burst sum
//   oOvf    out  1         overflow occurred during the burst
// ---------------------------------------------------------------------------
module acc_adder
   import acc_adder_pkg::*;
#(
   parameter int BITWIDTH = 32,
   parameter int ACCWIDTH = BITWIDTH + 8,
   parameter bit SAT      = 1'b0
) (
   input  logic                iClk,
   input  logic                iRst,
   input  logic                iClr,
   input  logic                iValid,
   output logic                oReady,
   input  logic [BITWIDTH-1:0] iData0,
   input  logic [BITWIDTH-1:0] iData1,
   input  logic                iLast,
   output logic                oValid,
   input  logic                iReady,
   output logic [ACCWIDTH-1:0] oData,
   output logic                oOvf
);

   localparam int PSUMWIDTH = BITWIDTH + 1;

   accState_t            state;
   accState_t            nextState;

   logic [PSUMWIDTH-1:0] psum;
   logic                 pvalid;
   logic                 plast;

   logic [ACCWIDTH-1:0]  acc;
   logic [ACCWIDTH-1:0]  accSum;
   logic                 ovf;
   logic                 carry;

   logic                 accept;
   logic                 lastPending;
   logic                 flush;

   // Reset and clear have the same effect. Reset is listed first because it
   // dominates, but the outcome is identical either way.
   assign flush = iRst | iClr;

   // A last beat sitting in stage 1 must not be followed by a new beat until
   // its result has been handed off. Otherwise the next burst would be folded
   // into the accumulator before it is cleared.
   assign lastPending = pvalid & plast;
   assign oReady      = (state == ACC) & ~lastPending;
   assign accept      = iValid & oReady;
   assign oValid      = (state == OUT);

   // Adder for the accumulator stage, with the overflow policy chosen by SAT.
   acc_sat_add #(
      .ACCWIDTH  (ACCWIDTH),
      .PSUMWIDTH (PSUMWIDTH),
      .SAT       (SAT)
   ) uSatAdd (
      .acc   (acc),
      .psum  (psum),
      .sum   (accSum),
      .carry (carry)
   );

   // State register. Reset or clear abandons any in-flight burst or pending
   // result and returns to accumulating.
   always_ff @(posedge iClk) begin
      if (flush) begin
         state <= ACC;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. A last pair sum reaching stage 2 closes the burst and
   // moves to OUT. OUT holds until the consumer takes the result.
   always_comb begin
      nextState = state;
      case (state)
         ACC: begin
            if (lastPending) begin
               nextState = OUT;
            end
         end
         OUT: begin
            if (iReady) begin
               nextState = ACC;
            end
         end
         default: begin
            nextState = ACC;
         end
      endcase
   end

   // Stage 1: register the pair sum at full BITWIDTH+1 precision, so nothing
   // is lost before accumulation. pvalid is only true in the cycle following
   // an accepted beat. plast is only meaningful while pvalid is set.
   always_ff @(posedge iClk) begin
      if (flush) begin
         pvalid <= 1'b0;
         plast  <= 1'b0;
         psum   <= '0;
      end else begin
         pvalid <= accept;
         if (accept) begin
            psum  <= {1'b0, iData0} + {1'b0, iData1};
            plast <= iLast;
         end
      end
   end

   // Stage 2: fold the pair sum into the accumulator and track the sticky
   // overflow flag. On the last pair of a burst, publish the final sum and
   // flag to the output registers. The accumulator is zeroed in the same edge,
   // so the next burst starts clean. The outputs stay frozen while in OUT,
   // because pvalid cannot be set there (oReady is low).
   always_ff @(posedge iClk) begin
      if (flush) begin
         acc   <= '0;
         ovf   <= 1'b0;
         oData <= '0;
         oOvf  <= 1'b0;
      end else if ((state == ACC) && pvalid) begin
         if (plast) begin
            oData <= accSum;
            oOvf  <= ovf | carry;
            acc   <= '0;
            ovf   <= 1'b0;
         end else begin
            acc   <= accSum;
            ovf   <= ovf | carry;
         end
      end
   end

endmodule

// File: tb/tb_acc_adder.sv
// ---------------------------------------------------------------------------
// tb_acc_adder
// Bench for acc_adder with BITWIDTH=8, ACCWIDTH=10. Two instances share all
// inputs, one wrapping (SAT=0) and one clamping (SAT=1). Their handshakes are
// data-independent, so both see identical beats. A negedge monitor keeps an
// arithmetic reference of each burst total and checks every result handshake
// against it. The main process runs directed scenarios with exact cycle
// checks, followed by randomized bursts under random backpressure.
// ---------------------------------------------------------------------------
module tb_acc_adder;

   localparam int BW   = 8;
   localparam int AW   = 10;
   localparam int AMAX = (1 << AW) - 1;

   logic          clk;
   logic          iRst;
   logic          iClr;
   logic          iValid;
   logic [BW-1:0] iData0;
   logic [BW-1:0] iData1;
   logic          iLast;
   logic          iReady;

   logic          oReady0, oReady1;
   logic          oValid0, oValid1;
   logic [AW-1:0] oData0, oData1;
   logic          oOvf0, oOvf1;

   int            checkCount = 0;
   int            passCount  = 0;
   int            readyMode  = 0;

   typedef struct {
      int wrapSum;
      int satSum;
      bit ovf;
   } expResult_t;

   expResult_t expQ[$];
   int         runTotal = 0;

   acc_adder #(.BITWIDTH(BW), .ACCWIDTH(AW), .SAT(1'b0)) dutWrap (
      .iClk   (clk),
      .iRst   (iRst),
      .iClr   (iClr),
      .iValid (iValid),
      .oReady (oReady0),
      .iData0 (iData0),
      .iData1 (iData1),
      .iLast  (iLast),
      .oValid (oValid0),
      .iReady (iReady),
      .oData  (oData0),
      .oOvf   (oOvf0)
   );

   acc_adder #(.BITWIDTH(BW), .ACCWIDTH(AW), .SAT(1'b1)) dutSat (
      .iClk   (clk),
      .iRst   (iRst),
      .iClr   (iClr),
      .iValid (iValid),
      .oReady (oReady1),
      .iData0 (iData0),
      .iData1 (iData1),
      .iLast  (iLast),
      .oValid (oValid1),
      .iReady (iReady),
      .oData  (oData1),
      .oOvf   (oOvf1)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point. Every check in the bench goes through here.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
      end else begin
         passCount++;
      end
   endtask

   // Present one beat and hold it until it is accepted, or until the cycle
   // budget runs out. Called and returns at posedge+1.
   task automatic applyStimulus(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                input logic last);
      int   waitCycles;
      logic taken;
      waitCycles = 0;
      taken      = 1'b0;
      iValid = 1'b1;
      iData0 = a;
      iData1 = b;
      iLast  = last;
      while (!taken && waitCycles < 60) begin
         @(negedge clk);
         taken = oReady0;
         @(posedge clk);
         #1;
         waitCycles++;
      end
      if (!taken) begin
         checkOutput("beatAccept", taken, 1);
      end
      iValid = 1'b0;
      iLast  = 1'b0;
   endtask

   // Wait (bounded) until a result is presented. Returns at posedge+1.
   task automatic waitResult();
      int waitCycles;
      waitCycles = 0;
      while (!oValid0 && waitCycles < 30) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      checkOutput("resultArrives", oValid0, 1);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Consumer side. iReady is driven at posedge+2, so a mode change made at
   // posedge+1 takes effect before the following edge.
   // Mode 0 = always ready, 1 = stalled, other = random.
   initial begin
      iReady = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (readyMode)
            0:       iReady = 1'b1;
            1:       iReady = 1'b0;
            default: iReady = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Reference model. It samples the handshakes at the negedge, where all
   // inputs and outputs are stable. Each burst total is computed in plain
   // integer arithmetic, and the wrapped and clamped results are derived
   // from that total.
   always @(negedge clk) begin : monitor
      expResult_t e;
      if (iRst || iClr) begin
         runTotal = 0;
         expQ.delete();
      end else begin
         if (oValid0 && iReady) begin
            checkOutput("resultExpected", expQ.size() != 0, 1);
            checkOutput("satValid", oValid1, 1);
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               checkOutput("wrapData", oData0, e.wrapSum);
               checkOutput("wrapOvf", oOvf0, e.ovf);
               checkOutput("satData", oData1, e.satSum);
               checkOutput("satOvf", oOvf1, e.ovf);
            end
         end
         if (iValid && oReady0) begin
            runTotal = runTotal + int'(iData0) + int'(iData1);
            if (iLast) begin
               e.wrapSum = runTotal % (AMAX + 1);
               e.satSum  = (runTotal > AMAX) ? AMAX : runTotal;
               e.ovf     = (runTotal > AMAX);
               expQ.push_back(e);
               runTotal = 0;
            end
         end
      end
   end

   // Overall time limit
   initial begin
      #800000;
      $display("[TB] FAIL watchdog: got timeout, want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main scenario sequence
   initial begin
      logic [BW-1:0] ra;
      logic [BW-1:0] rb;
      int            len;
      int            drain;

      iRst   = 1'b1;
      iClr   = 1'b0;
      iValid = 1'b0;
      iData0 = '0;
      iData1 = '0;
      iLast  = 1'b0;
      readyMode = 0;

      // Reset state
      repeat (3) stepCycle();
      checkOutput("rstValid", oValid0, 0);
      checkOutput("rstData", oData0, 0);
      checkOutput("rstOvf", oOvf0, 0);
      iRst = 1'b0;
      stepCycle();
      checkOutput("rstReady", oReady0, 1);

      // Basic burst with exact latency
      $display("[TB] basic burst");
      applyStimulus(8'd1, 8'd2, 1'b0);
      applyStimulus(8'd3, 8'd4, 1'b0);
      applyStimulus(8'd5, 8'd6, 1'b1);
      checkOutput("readyDropsAfterLast", oReady0, 0);
      checkOutput("noEarlyValid", oValid0, 0);
      stepCycle();
      checkOutput("basicValid", oValid0, 1);
      checkOutput("basicData", oData0, 21);
      checkOutput("basicOvf", oOvf0, 0);
      stepCycle();
      checkOutput("basicValidOneCycle", oValid0, 0);
      checkOutput("basicReadyBack", oReady0, 1);

      // Backpressure: result held, no beat taken while stalled
      $display("[TB] backpressure");
      readyMode = 1;
      applyStimulus(8'd1, 8'd2, 1'b0);
      applyStimulus(8'd3, 8'd4, 1'b0);
      applyStimulus(8'd5, 8'd6, 1'b1);
      waitResult();
      iValid = 1'b1;
      iData0 = 8'd9;
      iData1 = 8'd9;
      iLast  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bpValid", oValid0, 1);
         checkOutput("bpData", oData0, 21);
         checkOutput("bpReady", oReady0, 0);
         stepCycle();
      end
      readyMode = 0;
      stepCycle();
      checkOutput("bpValidDrop", oValid0, 0);
      checkOutput("bpReadyReturn", oReady0, 1);
      applyStimulus(8'd9, 8'd9, 1'b1);
      waitResult();
      checkOutput("bpNextData", oData0, 18);
      stepCycle();

      // Overflow, both policies
      $display("[TB] overflow");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'd255, 8'd255, 1'(i == 4));
      end
      waitResult();
      checkOutput("ovfWrapData", oData0, 502);
      checkOutput("ovfWrapFlag", oOvf0, 1);
      checkOutput("ovfSatData", oData1, 1023);
      checkOutput("ovfSatFlag", oOvf1, 1);
      stepCycle();
      applyStimulus(8'd1, 8'd1, 1'b1);
      waitResult();
      checkOutput("postOvfData", oData0, 2);
      checkOutput("postOvfFlag", oOvf0, 0);
      checkOutput("postOvfSatFlag", oOvf1, 0);
      stepCycle();

      // Single-beat bursts
      $display("[TB] single beat");
      applyStimulus(8'd0, 8'd0, 1'b1);
      waitResult();
      checkOutput("singleZero", oData0, 0);
      stepCycle();
      applyStimulus(8'd255, 8'd0, 1'b1);
      waitResult();
      checkOutput("single255", oData0, 255);
      stepCycle();

      // Clear mid-burst
      $display("[TB] clear mid-burst");
      applyStimulus(8'd10, 8'd10, 1'b0);
      applyStimulus(8'd10, 8'd10, 1'b0);
      iClr = 1'b1;
      stepCycle();
      iClr = 1'b0;
      checkOutput("clrReady", oReady0, 1);
      checkOutput("clrValid", oValid0, 0);
      applyStimulus(8'd7, 8'd8, 1'b1);
      waitResult();
      checkOutput("clrData", oData0, 15);
      checkOutput("clrOvf", oOvf0, 0);
      stepCycle();

      // Reset while a result is pending
      $display("[TB] reset during result");
      readyMode = 1;
      applyStimulus(8'd200, 8'd250, 1'b0);
      applyStimulus(8'd250, 8'd250, 1'b1);
      waitResult();
      checkOutput("preRstOvf", oOvf0, 0);
      iRst = 1'b1;
      stepCycle();
      checkOutput("midRstValid", oValid0, 0);
      checkOutput("midRstData", oData0, 0);
      checkOutput("midRstSatData", oData1, 0);
      checkOutput("midRstOvf", oOvf0, 0);
      iRst = 1'b0;
      readyMode = 0;
      stepCycle();
      checkOutput("postRstReady", oReady0, 1);
      checkOutput("postRstValid", oValid0, 0);

      // Randomized bursts under random backpressure
      $display("[TB] random bursts");
      readyMode = 2;
      for (int b = 0; b < 40; b++) begin
         len = $urandom_range(1, 6);
         for (int j = 0; j < len; j++) begin
            if ((b % 3) == 0) begin
               ra = 8'($urandom_range(180, 255));
               rb = 8'($urandom_range(180, 255));
            end else begin
               ra = 8'($urandom_range(0, 255));
               rb = 8'($urandom_range(0, 255));
            end
            applyStimulus(ra, rb, 1'(j == len - 1));
            repeat ($urandom_range(0, 1)) stepCycle();
         end
      end

      // Drain any outstanding result
      readyMode = 0;
      drain = 0;
      while ((expQ.size() != 0 || oValid0) && drain < 40) begin
         stepCycle();
         drain++;
      end
      checkOutput("drainEmpty", expQ.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
